// File: rtl/pc_sequencer.sv
// pc_sequencer: control FSM for the fetch-stage PC register.
// Produces registered nPC_sel / steve (PC hold) from branch decode, stall
// requests and halt/resume, plus a saturating count of PC-advance cycles.
module pc_sequencer #(
    parameter int unsigned RESET_HOLD = 2,
    parameter int unsigned STALL_W    = 4,
    parameter int unsigned ADV_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               branch_eq,
    input  logic               branch_ne,
    input  logic               alu_zero,
    input  logic               stall_req,
    input  logic [STALL_W-1:0] stall_len,
    input  logic               halt,
    input  logic               resume,
    output logic               nPC_sel,
    output logic               steve,
    output logic               flush,
    output logic               branch_err,
    output logic [1:0]         state,
    output logic [ADV_W-1:0]   adv_count
);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    // Hold counter only needs to reach RESET_HOLD-1; RESET_HOLD of 0 or 1
    // both leave INIT on the first edge, so a 1-bit counter suffices there.
    localparam int unsigned HOLD_W    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam int unsigned HOLD_LAST = (RESET_HOLD > 0) ? RESET_HOLD - 1 : 0;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic                pending_q, pending_d;
    logic                steve_q, steve_d;
    logic                npc_sel_q, npc_sel_d;
    logic                flush_q, flush_d;
    logic                branch_err_q, branch_err_d;
    logic [ADV_W-1:0]    adv_count_q, adv_count_d;

    logic                taken;
    logic                both_br;
    logic                stall_go;

    assign both_br  = branch_eq & branch_ne;
    assign taken    = (branch_eq & alu_zero) | (branch_ne & ~alu_zero);
    assign stall_go = stall_req & (stall_len != '0);

    // Next-state and registered-output decode for the sequencer FSM.
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        pending_d    = pending_q;
        steve_d      = 1'b1;
        npc_sel_d    = 1'b0;
        flush_d      = 1'b0;
        branch_err_d = 1'b0;

        unique case (state_q)
            S_INIT: begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                if (hold_cnt_q == HOLD_W'(HOLD_LAST)) begin
                    state_d = S_RUN;
                    steve_d = 1'b0;
                end
            end

            S_RUN: begin
                branch_err_d = both_br;
                if (halt) begin
                    state_d   = S_HALT;
                    pending_d = taken;
                end else if (stall_go) begin
                    state_d     = S_STALL;
                    stall_cnt_d = stall_len - STALL_W'(1);
                    pending_d   = taken;
                end else begin
                    steve_d   = 1'b0;
                    npc_sel_d = taken;
                    flush_d   = taken;
                end
            end

            S_STALL: begin
                if (halt) begin
                    state_d = S_HALT;
                end else if (stall_cnt_q == '0) begin
                    state_d   = S_RUN;
                    steve_d   = 1'b0;
                    npc_sel_d = pending_q;
                    flush_d   = pending_q;
                    pending_d = 1'b0;
                end else begin
                    stall_cnt_d = stall_cnt_q - STALL_W'(1);
                end
            end

            S_HALT: begin
                if (resume && !halt) begin
                    state_d   = S_RUN;
                    steve_d   = 1'b0;
                    npc_sel_d = pending_q;
                    flush_d   = pending_q;
                    pending_d = 1'b0;
                end
            end

            default: state_d = S_INIT;
        endcase
    end

    // Saturating count of cycles in which the PC was allowed to advance.
    always_comb begin
        adv_count_d = adv_count_q;
        if (!steve_q && (adv_count_q != '1)) begin
            adv_count_d = adv_count_q + ADV_W'(1);
        end
    end

    // State and output registers; reset drops everything including pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_INIT;
            hold_cnt_q   <= '0;
            stall_cnt_q  <= '0;
            pending_q    <= 1'b0;
            steve_q      <= 1'b1;
            npc_sel_q    <= 1'b0;
            flush_q      <= 1'b0;
            branch_err_q <= 1'b0;
            adv_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            pending_q    <= pending_d;
            steve_q      <= steve_d;
            npc_sel_q    <= npc_sel_d;
            flush_q      <= flush_d;
            branch_err_q <= branch_err_d;
            adv_count_q  <= adv_count_d;
        end
    end

    assign state      = state_q;
    assign steve      = steve_q;
    assign nPC_sel    = npc_sel_q;
    assign flush      = flush_q;
    assign branch_err = branch_err_q;
    assign adv_count  = adv_count_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Control FSM that sequences the fetch-stage PC register for the single-cycle CPU. It generates `nPC_sel` (branch select) and `steve` (PC hold) from the branch/zero decode, multi-cycle stall requests and halt/resume. All outputs are registered on posedge `clk`, so they are stable before the PC register's negedge update. It also keeps a saturating count of cycles in which the PC advanced.

Parameters:
- `RESET_HOLD`, 2: cycles `steve` stays high after reset deasserts before fetch begins (0 = start immediately).
- `STALL_W`, 4: width of the stall length input and the stall counter.
- `ADV_W`, 16: width of the PC-advance counter.

Ports:
- `clk`  in  1  system clock; all state changes on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `branch_eq`  in  1  decoded beq.
- `branch_ne`  in  1  decoded bne.
- `alu_zero`  in  1  ALU zero flag.
- `stall_req`  in  1  request to hold the PC (sampled in RUN only).
- `stall_len`  in  STALL_W  number of hold cycles; sampled with `stall_req`.
- `halt`  in  1  stop fetch until `resume`.
- `resume`  in  1  leave HALT.
- `nPC_sel`  out  1  1 = PC takes branch target this cycle.
- `steve`  out  1  1 = PC register holds its value.
- `flush`  out  1  one-cycle pulse accompanying every issued branch.
- `branch_err`  out  1  one-cycle pulse when `branch_eq` and `branch_ne` are both high.
- `state`  out  2  0 = INIT, 1 = RUN, 2 = STALL, 3 = HALT.
- `adv_count`  out  ADV_W  count of cycles with `steve` = 0, saturating.

Behaviour:
- **Reset (async, `rst_n` = 0):** `state` = INIT, `steve` = 1, `nPC_sel` = 0, `flush` = 0, `branch_err` = 0, `adv_count` = 0. Internal hold counter = 0, stall counter = 0, `pending` = 0. Reset mid-stall or mid-halt discards all state, including `pending`.
- **Taken branch:** `taken` = (`branch_eq` & `alu_zero`) | (`branch_ne` & ~`alu_zero`).
  - If `branch_eq` & `branch_ne` both high: `taken` = 1 and `branch_err` pulses 1 cycle.
- **INIT:**
  - `steve` = 1; the hold counter increments each posedge.
  - Transition to RUN on the edge where the counter = `RESET_HOLD`-1.
  - With `RESET_HOLD` = 0, go to RUN on the first posedge after reset release.
  - All other inputs are ignored in INIT.
- **RUN (per posedge, priority `halt` > `stall_req` > `taken`):**
  - `halt`: next state HALT, `steve` = 1, `nPC_sel` = 0. If `taken`, set `pending` = 1.
  - `stall_req` with `stall_len` = N > 0: next state STALL, `steve` = 1, stall counter = N-1. If `taken`, set `pending` = 1.
  - `stall_req` with `stall_len` = 0: treated as no request.
  - `taken` alone: `steve` = 0, `nPC_sel` = 1, `flush` = 1 for exactly one cycle.
  - Otherwise: `steve` = 0, `nPC_sel` = 0.
- **STALL:**
  - `steve` = 1 for exactly N cycles in total, counted from the entry edge.
  - The counter decrements each edge. When it is 0, return to RUN with `steve` = 0, `nPC_sel` = `pending`, `flush` = `pending`; clear `pending`.
  - `stall_req` and branch inputs are ignored in STALL.
  - `halt` in STALL: go to HALT immediately; `pending` is retained.
- **HALT:**
  - `steve` = 1 while in HALT.
  - `resume` = 1: return to RUN next edge with `nPC_sel` = `pending`, `flush` = `pending`; clear `pending`.
  - `halt` and `resume` both high: stay in HALT.
- **`adv_count`:** +1 on each edge where the registered `steve` = 0. Saturates at all-ones (no wrap).
- **Width rules:** all counters are unsigned; `stall_len` is zero-extended where needed.

Test Plan:
1. Reset release, `RESET_HOLD` = 2, no requests -> `steve` = 1 for 2 posedges, then `state` = 1, `steve` = 0; `adv_count` increments 1, 2, 3…
2. RUN, `branch_eq` = 1, `alu_zero` = 1 for one cycle -> `nPC_sel` = 1 and `flush` = 1 for exactly 1 cycle. Repeat with `branch_ne` = 1, `alu_zero` = 1 -> `nPC_sel` stays 0.
3. `stall_req` = 1, `stall_len` = 3, with a simultaneous taken `branch_eq` -> `state` = 2 and `steve` = 1 for 3 cycles, then `nPC_sel` = 1 and `flush` = 1 on the first RUN cycle. Repeat with `stall_len` = 0 -> no stall, branch issued immediately.
4. `halt` during STALL with `pending` set; `resume` pulsed 5 cycles later -> `state` 2→3, `steve` held, then RUN with `nPC_sel` = 1 for one cycle.
5. `branch_eq` = `branch_ne` = 1, `alu_zero` = 0 -> `nPC_sel` = 1 and `branch_err` = 1 for one cycle.
6. `rst_n` dropped asynchronously mid-STALL -> outputs return to reset values without waiting for a clock edge. With `ADV_W` = 4, 20 free-running cycles -> `adv_count` stops at 15.
